// File: rtl/bus_irq_pkg.sv
// Shared constants and types for the bus interrupt controller.
package bus_irq_pkg;
  localparam int          NSRC      = 8;
  localparam logic [15:0] BASE      = 16'hFE00;
  localparam logic [7:0]  VECT_NONE = 8'h80;

  localparam logic [2:0] OFF_PEND  = 3'd0;
  localparam logic [2:0] OFF_MASK  = 3'd1;
  localparam logic [2:0] OFF_EDGE  = 3'd2;
  localparam logic [2:0] OFF_POL   = 3'd3;
  localparam logic [2:0] OFF_VECT  = 3'd4;
  localparam logic [2:0] OFF_SWSET = 3'd5;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [2:0] off;
    logic [7:0] data;
  } bus_req_t;

  // Lowest-numbered set bit wins; VECT_NONE when nothing is set.
  function automatic logic [7:0] vect_enc(input logic [NSRC-1:0] v);
    logic [7:0] r;
    r = VECT_NONE;
    for (int i = NSRC - 1; i >= 0; i--)
      if (v[i]) r = {5'd0, 3'(i)};
    return r;
  endfunction
endpackage

// File: rtl/bus_irq_ctrl_if.sv
// CPU-side register bus of the interrupt controller.
interface bus_irq_ctrl_if;
  logic [15:0] AB;
  logic        WE;
  logic [7:0]  DO;
  logic [7:0]  DB;
  logic        hit;

  modport master (output AB, WE, DO, input DB, hit);
  modport slave  (input AB, WE, DO, output DB, hit);
endinterface

// File: rtl/irq_sync.sv
// One source lane: 2-flop synchronizer, polarity flip and rising-edge detect.
module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic pol,
  input  logic en,
  input  logic reload,
  output logic act,
  output logic rise
);
  logic s1, s2, prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= src;
      s2   <= s1;
      prev <= act;
    end
  end

  assign act = s2 ^ pol;
  // History is stale while the synchronizer fills or right after a config change.
  assign rise = en & ~reload & act & ~prev;
endmodule

// File: rtl/bus_irq_ctrl.sv
// Memory-mapped interrupt controller: pending/mask/edge/polarity regs and a vector read.
module bus_irq_ctrl
  import bus_irq_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  output logic            irq,
  bus_irq_ctrl_if.slave   bus
);
  localparam int STAGES = 2;

  logic [STAGES:0]  vld_pipe;
  bus_req_t         req;
  logic             sel, ack;
  logic [NSRC-1:0]  pend, mask, edge_mode, pol, act, rise, reload_q;
  logic [NSRC-1:0]  cfg_chg, set_v, clr_v, ack_mask, pend_n;
  logic [7:0]       vect, rdata;

  assign sel      = bus.AB[15:3] == BASE[15:3];
  assign req.rd   = sel & ~bus.WE;
  assign req.wr   = sel & bus.WE;
  assign req.off  = bus.AB[2:0];
  assign req.data = bus.DO;

  irq_sync u_sync [NSRC-1:0] (
    .clk    (clk),
    .reset  (reset),
    .src    (src),
    .pol    (pol),
    .en     (vld_pipe[STAGES]),
    .reload (reload_q),
    .act    (act),
    .rise   (rise)
  );

  assign vect     = vect_enc(pend & mask);
  assign ack      = req.rd && req.off == OFF_VECT && !vect[7];
  assign ack_mask = ack ? (NSRC'(1) << vect[2:0]) : '0;

  always_comb begin
    cfg_chg = '0;
    if (req.wr && req.off == OFF_EDGE) cfg_chg = req.data ^ edge_mode;
    if (req.wr && req.off == OFF_POL)  cfg_chg = req.data ^ pol;
  end

  assign set_v = rise | ((req.wr && req.off == OFF_SWSET) ? req.data : '0);
  assign clr_v = ((req.wr && req.off == OFF_PEND) ? req.data : '0) | ack_mask;
  // Level bits mirror act; edge bits hold with set beating clear.
  assign pend_n = ~cfg_chg & ((~edge_mode & act) |
                              (edge_mode & (set_v | (pend & ~clr_v))));

  always_comb begin
    case (req.off)
      OFF_PEND: rdata = pend;
      OFF_MASK: rdata = mask;
      OFF_EDGE: rdata = edge_mode;
      OFF_POL:  rdata = pol;
      OFF_VECT: rdata = vect;
      default:  rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      pend      <= '0;
      mask      <= '0;
      edge_mode <= '0;
      pol       <= '0;
      reload_q  <= '0;
      bus.DB    <= 8'h00;
      bus.hit   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      pend     <= pend_n;
      reload_q <= cfg_chg;
      if (req.wr) begin
        case (req.off)
          OFF_MASK: mask      <= req.data;
          OFF_EDGE: edge_mode <= req.data;
          OFF_POL:  pol       <= req.data;
          default: ;
        endcase
      end
      bus.DB  <= req.rd ? rdata : 8'h00;
      bus.hit <= req.rd;
      irq     <= |(pend & mask);
    end
  end
endmodule
